// File: rtl/alu_exec_if.sv
// Request/result bundle for alu_exec: operation handshake in, result handshake out.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Multi-cycle ALU: one-cycle arithmetic/compare ops, iterative shifts of SHIFT_STEP bits per cycle.
// Latency 1 (+ceil(shamt/SHIFT_STEP) for shifts); result held in DONE until out_ready, no accept meanwhile.
module alu_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic      clk,
  input  logic      rst,
  alu_exec_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shk_t;

  state_t          state_q, state_d;
  shk_t            shk_q, shk_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            is_shift;
  shk_t            shk_in;
  logic [SHW-1:0]  step;
  logic [XLEN-1:0] shifted;

  // Single-cycle datapath, evaluated on the live inputs at accept.
  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    shk_in   = SH_LL;
    unique case (bus.alu_op)
      4'b0000: alu_res = bus.op_a + bus.op_b;
      4'b1000: alu_res = bus.op_a - bus.op_b;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
      4'b0100: alu_res = bus.op_a ^ bus.op_b;
      4'b0110: alu_res = bus.op_a | bus.op_b;
      4'b0111: alu_res = bus.op_a & bus.op_b;
      4'b1001: alu_res = {{(XLEN-1){1'b0}}, bus.op_a == bus.op_b};
      4'b1010: alu_res = {{(XLEN-1){1'b0}}, bus.op_a != bus.op_b};
      4'b1100: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) >= $signed(bus.op_b)};
      4'b1110: alu_res = {{(XLEN-1){1'b0}}, bus.op_a >= bus.op_b};
      4'b0001: begin is_shift = 1'b1; shk_in = SH_LL; end
      4'b0101: begin is_shift = 1'b1; shk_in = SH_RL; end
      4'b1101: begin is_shift = 1'b1; shk_in = SH_RA; end
      default: alu_ill = 1'b1;
    endcase
  end

  // SRA keeps the MSB through every step, so the fill is always the original sign.
  always_comb begin
    step    = (cnt_q < STEP) ? cnt_q : STEP;
    shifted = work_q;
    unique case (shk_q)
      SH_LL:   shifted = work_q << step;
      SH_RL:   shifted = work_q >> step;
      SH_RA:   shifted = $signed(work_q) >>> step;
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shk_d       = shk_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (is_shift && (bus.op_b[SHW-1:0] != '0)) begin
            state_d = SHIFT;
            shk_d   = shk_in;
            work_d  = bus.op_a;
            cnt_d   = bus.op_b[SHW-1:0];
          end else begin
            state_d     = DONE;
            result_d    = is_shift ? bus.op_a : alu_res;
            zero_d      = is_shift ? (bus.op_a == '0) : (alu_res == '0);
            illegal_d   = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - step;
        if (cnt_q == step) begin
          state_d     = DONE;
          result_d    = shifted;
          zero_d      = (shifted == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shk_q       <= SH_LL;
      work_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shk_q       <= shk_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: two instances (SHIFT_STEP 1 and 4) driven in lockstep, directed table plus random ops.
module tb_alu_exec;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  alu_op;
  logic [31:0] op_a, op_b;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_if #(.XLEN(32)) if1 ();
  alu_exec_if #(.XLEN(32)) if4 ();

  assign if1.in_valid  = in_valid;
  assign if1.alu_op    = alu_op;
  assign if1.op_a      = op_a;
  assign if1.op_b      = op_b;
  assign if1.out_ready = out_ready;
  assign if4.in_valid  = in_valid;
  assign if4.alu_op    = alu_op;
  assign if4.op_a      = op_a;
  assign if4.op_b      = op_b;
  assign if4.out_ready = out_ready;

  alu_exec #(.XLEN(32), .SHIFT_STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  alu_exec #(.XLEN(32), .SHIFT_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference behaviour straight from the opcode table.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'd0;
    ill = 1'b0;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << sh;
      4'b0101: r = a >> sh;
      4'b1101: r = $unsigned($signed(a) >>> sh);
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1001: r = (a == b) ? 32'd1 : 32'd0;
      4'b1010: r = (a != b) ? 32'd1 : 32'd0;
      4'b1100: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'b1110: r = (a >= b) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b, input int stp);
    int sh;
    sh = int'(b[4:0]);
    if ((op == 4'b0001 || op == 4'b0101 || op == 4'b1101) && sh != 0)
      return 1 + (sh + stp - 1) / stp;
    return 1;
  endfunction

  // Called at posedge+1 with both DUTs idle; returns at posedge+1 with both idle again.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eill, input int l1, input int l4, input int hold);
    int lat1, lat4, n;
    chk({nm, " in_ready"}, {31'd0, if1.in_ready & if4.in_ready}, 32'd1);
    in_valid  = 1'b1;
    alu_op    = op;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op   = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    lat1 = 0; lat4 = 0; n = 1;
    while ((lat1 == 0 || lat4 == 0) && n < 100) begin
      if (lat1 == 0 && if1.out_valid) lat1 = n;
      if (lat4 == 0 && if4.out_valid) lat4 = n;
      if (lat1 == 0 || lat4 == 0) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk({nm, " lat1"}, lat1, l1);
    chk({nm, " lat4"}, lat4, l4);
    chk({nm, " res1"}, if1.result, er);
    chk({nm, " res4"}, if4.result, er);
    chk({nm, " zero1"}, {31'd0, if1.zero}, {31'd0, er == 32'd0});
    chk({nm, " ill1"}, {31'd0, if1.illegal}, {31'd0, eill});
    chk({nm, " ill4"}, {31'd0, if4.illegal}, {31'd0, eill});
    chk({nm, " busy"}, {31'd0, if1.in_ready | if4.in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      alu_op   = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      @(posedge clk); #1;
      chk({nm, " hold res"}, if1.result, er);
      chk({nm, " hold vld"}, {31'd0, if1.out_valid & if4.out_valid}, 32'd1);
      chk({nm, " hold rdy"}, {31'd0, if1.in_ready | if4.in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({nm, " drop vld"}, {31'd0, if1.out_valid | if4.out_valid}, 32'd0);
    chk({nm, " back idle"}, {31'd0, if1.in_ready & if4.in_ready}, 32'd1);
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic        eill;
    int          l1;
    int          l4;
    int          hold;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [31:0] r;
    logic        ill;
    logic [3:0]  op;
    logic [31:0] a, b;
    int          seen;

    vecs[0]  = '{"add",      4'b0000, 32'd5,          32'd7,          32'd12,         1'b0, 1,  1, 0};
    vecs[1]  = '{"sub_wrap", 4'b1000, 32'd0,          32'd1,          32'hFFFFFFFF,   1'b0, 1,  1, 0};
    vecs[2]  = '{"sltu",     4'b0011, 32'd1,          32'hFFFFFFFF,   32'd1,          1'b0, 1,  1, 0};
    vecs[3]  = '{"slt",      4'b0010, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1,  1, 0};
    vecs[4]  = '{"sra4",     4'b1101, 32'h80000000,   32'd4,          32'hF8000000,   1'b0, 5,  2, 0};
    vecs[5]  = '{"sra0",     4'b1101, 32'h80000000,   32'd0,          32'h80000000,   1'b0, 1,  1, 0};
    vecs[6]  = '{"ill1011",  4'b1011, 32'd7,          32'd9,          32'd0,          1'b1, 1,  1, 0};
    vecs[7]  = '{"eq",       4'b1001, 32'd3,          32'd3,          32'd1,          1'b0, 1,  1, 0};
    vecs[8]  = '{"neq",      4'b1010, 32'd3,          32'd3,          32'd0,          1'b0, 1,  1, 0};
    vecs[9]  = '{"ge",       4'b1100, 32'hFFFFFFFF,   32'd0,          32'd0,          1'b0, 1,  1, 0};
    vecs[10] = '{"geu",      4'b1110, 32'hFFFFFFFF,   32'd0,          32'd1,          1'b0, 1,  1, 0};
    vecs[11] = '{"sll31",    4'b0001, 32'd1,          32'd31,         32'h80000000,   1'b0, 32, 9, 0};
    vecs[12] = '{"srl31",    4'b0101, 32'h80000000,   32'd31,         32'd1,          1'b0, 32, 9, 0};
    vecs[13] = '{"xor",      4'b0100, 32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   1'b0, 1,  1, 0};
    vecs[14] = '{"or",       4'b0110, 32'hF0F0F0F0,   32'h0000FF00,   32'hF0F0FFF0,   1'b0, 1,  1, 0};
    vecs[15] = '{"and",      4'b0111, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   1'b0, 1,  1, 0};
    vecs[16] = '{"ill1111",  4'b1111, 32'h12345678,   32'd1,          32'd0,          1'b1, 1,  1, 1};
    vecs[17] = '{"add_bp",   4'b0000, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1,  1, 3};
    vecs[18] = '{"sll_mask", 4'b0001, 32'd3,          32'h00000021,   32'd6,          1'b0, 2,  2, 0};
    vecs[19] = '{"srl6",     4'b0101, 32'hF0000000,   32'd6,          32'h03C00000,   1'b0, 7,  3, 2};

    rst = 1'b1; in_valid = 1'b0; alu_op = 4'd0; op_a = 32'd0; op_b = 32'd0; out_ready = 1'b0;
    #1;
    chk("rst in_ready",  {31'd0, if1.in_ready},  32'd1);
    chk("rst out_valid", {31'd0, if1.out_valid | if4.out_valid}, 32'd0);
    chk("rst result",    if1.result | if4.result, 32'd0);
    chk("rst zero",      {31'd0, if1.zero & if4.zero}, 32'd1);
    chk("rst illegal",   {31'd0, if1.illegal | if4.illegal}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].er, vecs[i].eill,
             vecs[i].l1, vecs[i].l4, vecs[i].hold);

    // out_ready with nothing to deliver must change nothing.
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle ordy vld", {31'd0, if1.out_valid}, 32'd0);
    chk("idle ordy rdy", {31'd0, if1.in_ready},  32'd1);
    chk("idle ordy res", if1.result, 32'hF0000000 >> 6);

    // Reset in the middle of a long shift.
    in_valid = 1'b1; alu_op = 4'b0001; op_a = 32'd1; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid vld",  {31'd0, if1.out_valid | if4.out_valid}, 32'd0);
    chk("rstmid res",  if1.result | if4.result, 32'd0);
    chk("rstmid rdy",  {31'd0, if1.in_ready & if4.in_ready}, 32'd1);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (if1.out_valid || if4.out_valid) seen++;
    end
    chk("rstmid late", seen, 0);
    chk("rstmid zero", {31'd0, if1.zero}, 32'd1);

    for (int t = 0; t < 120; t++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 31));
        default: b = $urandom;
      endcase
      ref_alu(op, a, b, r, ill);
      run_op($sformatf("rnd%0d", t), op, a, b, r, ill, ref_lat(op, b, 1), ref_lat(op, b, 4),
             int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width in bits.
REQ-002 The block SHALL have parameter SHIFT_STEP, default 1, meaning shift bit positions per cycle; legal values are 1, 2, 4 and 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 The block SHALL have port alu_op, input, 4 bits: operation code, sampled at accept.
REQ-008 The block SHALL have ports op_a and op_b, input, XLEN bits each: operands, sampled at accept.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port result, output, XLEN bits: operation result.
REQ-012 The block SHALL have port zero, output, 1 bit: result equals 0.
REQ-013 The block SHALL have port illegal, output, 1 bit: the accepted alu_op was unassigned.

Function
REQ-014 alu_op codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, EQ 1001, NEQ 1010, GE 1100, GEU 1110; 1011 and 1111 are illegal.
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1; operands and op are captured into internal registers, and later input changes have no effect.
REQ-017 Non-shift op accepted: IDLE->DONE; result, zero and illegal are registered, and out_valid=1 on the cycle after accept (latency 1).
REQ-018 Shift op (SLL/SRL/SRA) accepted: shamt = op_b[4:0] (log2(XLEN) bits); if shamt=0, IDLE->DONE with result=op_a; else IDLE->SHIFT.
REQ-019 In SHIFT, each cycle the working value SHALL shift by min(SHIFT_STEP, remaining) and remaining decrements by the same amount; SRA fills with the original sign bit, and SLL/SRL fill with 0.
REQ-020 SHIFT->DONE on the cycle remaining reaches 0; total latency from accept to out_valid is 1+ceil(shamt/SHIFT_STEP) cycles.
REQ-021 ADD/SUB SHALL wrap modulo 2^XLEN with no carry or overflow output.
REQ-022 SLT and GE SHALL compare as signed; SLTU and GEU SHALL compare as unsigned.
REQ-023 SLT, SLTU, EQ, NEQ, GE and GEU SHALL produce result 1 when true and 0 when false, zero-extended to XLEN.
REQ-024 An illegal op SHALL take the non-shift path, giving result 0, zero=1 and illegal=1.
REQ-025 DONE SHALL hold out_valid=1 and keep result, zero and illegal stable until out_ready=1; on that cycle the FSM goes DONE->IDLE.
REQ-026 No new accept SHALL occur in the out_ready cycle; the next accept is possible one cycle later.
REQ-027 Outside DONE, result, zero and illegal SHALL hold their last values, and out_valid SHALL be 0.
REQ-028 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-029 While rst=1, state SHALL be IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0, and internal shift registers and count SHALL be 0.
REQ-030 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no result is presented after release.
REQ-031 The first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-032 Directed scenario, ADD: ADD op_a=5, op_b=7, out_ready=1 -> result=12, zero=0, and out_valid on the cycle after accept for exactly 1 cycle.
REQ-033 Directed scenario, SUB wrap: SUB op_a=0, op_b=1 -> result=0xFFFFFFFF; then SLTU 1 vs 0xFFFFFFFF -> result=1, and SLT with the same operands -> result=0.
REQ-034 Directed scenario, SRA: SHIFT_STEP=1, SRA op_a=0x80000000, op_b=4 -> result=0xF8000000 with out_valid 5 cycles after accept; with SHIFT_STEP=4 -> 2 cycles; shamt=0 -> 1 cycle, result=op_a.
REQ-035 Directed scenario, backpressure: out_ready held 0 for 3 cycles in DONE -> result stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE, and the next accept follows 1 cycle later.
REQ-036 Directed scenario, reset mid-shift: rst pulsed during SLL by 20 -> out_valid=0, result=0, in_ready=1 immediately, and no late result appears.
REQ-037 Directed scenario, illegal op: alu_op=1011 -> result=0, zero=1, illegal=1; the following legal EQ with 3,3 -> result=1, illegal=0.
